// File: rtl/mt_pkg.sv
// MT11213B constants, tempering helper and FSM types shared by the
// Mersenne-Twister engine.
package mt_pkg;

    localparam int unsigned N = 351;
    localparam int unsigned M = 175;
    localparam int unsigned R = 19;

    localparam logic [31:0] LOWER = (32'd1 << R) - 32'd1;
    localparam logic [31:0] UPPER = ~LOWER;
    localparam logic [31:0] A     = 32'hE4BD_75F5;
    localparam logic [31:0] F     = 32'd1812433253;

    localparam int unsigned T_U = 11;
    localparam int unsigned T_S = 7;
    localparam int unsigned T_T = 15;
    localparam int unsigned T_L = 17;
    localparam logic [31:0] T_B = 32'h655E_5280;
    localparam logic [31:0] T_C = 32'hFFD5_8000;

    localparam int IDX_W = 9;
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t LAST = idx_t'(N - 1);

    typedef enum logic [1:0] {
        ST_SEED,
        ST_TWIST,
        ST_OUTPUT
    } mt_state_e;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_REQ,
        BUS_WAIT
    } bus_phase_e;

    typedef enum logic [1:0] {
        TW_CUR,
        TW_NXT,
        TW_MID,
        TW_WR
    } tw_step_e;

    function automatic logic [31:0] temper(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x >> T_U);
        y = y ^ ((y << T_S) & T_B);
        y = y ^ ((y << T_T) & T_C);
        y = y ^ (y >> T_L);
        return y;
    endfunction

endpackage

// File: rtl/mt_temper.sv
// Registered tempering stage; holds its word until the consumer takes it.
module mt_temper
    import mt_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic [31:0] data_i,
    input  logic        hold_i,
    output logic        valid_o,
    output logic [31:0] data_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (valid_i) begin
            valid_o <= 1'b1;
            data_o  <= temper(data_i);
        end else if (!hold_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/mt_twister.sv
// MT11213B engine: seeds, twists and reads its state array in shared RAM
// over a Wishbone master port and streams tempered words.
module mt_twister
    import mt_pkg::*;
#(
    parameter logic [8:0]  BASE_ADDR    = 9'h000,
    parameter logic [31:0] SEED_DEFAULT = 32'd5489
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] seed_i,
    input  logic        seed_valid_i,
    output logic        busy_o,
    output logic [31:0] rnd_data_o,
    output logic        rnd_valid_o,
    input  logic        rnd_ready_i,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    output logic [3:0]  m_wb_we_o,
    output logic [8:0]  m_wb_addr_o,
    output logic [31:0] m_wb_data_o,
    input  logic        m_wb_ack_i,
    input  logic        m_wb_stall_i,
    input  logic [31:0] m_wb_data_i
);

    mt_state_e   state;
    bus_phase_e  phase;
    tw_step_e    step;
    idx_t        idx;
    logic [31:0] s_q;
    logic [31:0] x_cur;
    logic [31:0] x_nxt;
    logic [31:0] x_mid;
    logic        pend;
    logic [31:0] pend_seed;

    logic        rs;
    logic [31:0] rs_seed;
    logic        can_go;
    logic        out_load;
    idx_t        nxt_idx;
    idx_t        mid_idx;
    logic [9:0]  mid_sum;
    logic [31:0] y;
    logic [31:0] twist_word;
    logic [31:0] seed_word;
    logic        req_we;
    idx_t        req_idx;
    logic [31:0] req_data;

    assign rs       = pend | seed_valid_i;
    assign rs_seed  = seed_valid_i ? seed_i : pend_seed;
    assign can_go   = !rnd_valid_o || rnd_ready_i;
    assign busy_o   = (state != ST_OUTPUT);
    assign out_load = (phase == BUS_WAIT) && m_wb_ack_i &&
                      (state == ST_OUTPUT) && !rs;

    assign nxt_idx = (idx == LAST) ? '0 : idx + 1'b1;
    assign mid_sum = {1'b0, idx} + 10'(M);
    assign mid_idx = (mid_sum >= 10'(N)) ? idx_t'(mid_sum - 10'(N))
                                         : idx_t'(mid_sum);

    assign y          = (x_cur & UPPER) | (x_nxt & LOWER);
    assign twist_word = x_mid ^ (y >> 1) ^ (y[0] ? A : 32'd0);
    assign seed_word  = (idx == '0) ? s_q
                      : F * (s_q ^ (s_q >> 30)) + 32'(idx);

    always_comb begin
        req_we   = 1'b0;
        req_idx  = idx;
        req_data = '0;
        unique case (state)
            ST_SEED: begin
                req_we   = 1'b1;
                req_data = seed_word;
            end
            ST_TWIST: begin
                unique case (step)
                    TW_NXT: req_idx = nxt_idx;
                    TW_MID: req_idx = mid_idx;
                    TW_WR: begin
                        req_we   = 1'b1;
                        req_data = twist_word;
                    end
                    default: req_idx = idx;
                endcase
            end
            default: req_idx = idx;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_SEED;
            phase       <= BUS_IDLE;
            step        <= TW_CUR;
            idx         <= '0;
            s_q         <= SEED_DEFAULT;
            x_cur       <= '0;
            x_nxt       <= '0;
            x_mid       <= '0;
            pend        <= 1'b0;
            pend_seed   <= '0;
            m_wb_cyc_o  <= 1'b0;
            m_wb_stb_o  <= 1'b0;
            m_wb_we_o   <= '0;
            m_wb_addr_o <= '0;
            m_wb_data_o <= '0;
        end else begin
            if (seed_valid_i && phase != BUS_IDLE) begin
                pend      <= 1'b1;
                pend_seed <= seed_i;
            end
            unique case (phase)
                BUS_IDLE: begin
                    if (seed_valid_i) begin
                        state <= ST_SEED;
                        idx   <= '0;
                        s_q   <= seed_i;
                    end else if (can_go) begin
                        m_wb_cyc_o  <= 1'b1;
                        m_wb_stb_o  <= 1'b1;
                        m_wb_we_o   <= req_we ? 4'hF : 4'h0;
                        m_wb_addr_o <= BASE_ADDR + req_idx;
                        m_wb_data_o <= req_data;
                        phase       <= BUS_REQ;
                    end
                end
                BUS_REQ: begin
                    if (!m_wb_stall_i) begin
                        m_wb_stb_o <= 1'b0;
                        phase      <= BUS_WAIT;
                    end
                end
                BUS_WAIT: begin
                    if (m_wb_ack_i) begin
                        m_wb_cyc_o <= 1'b0;
                        phase      <= BUS_IDLE;
                        if (rs) begin
                            state <= ST_SEED;
                            idx   <= '0;
                            s_q   <= rs_seed;
                            pend  <= 1'b0;
                        end else begin
                            unique case (state)
                                ST_SEED: begin
                                    // the word just written seeds the next one
                                    s_q <= m_wb_data_o;
                                    if (idx == LAST) begin
                                        state <= ST_TWIST;
                                        idx   <= '0;
                                        step  <= TW_CUR;
                                    end else begin
                                        idx <= idx + 1'b1;
                                    end
                                end
                                ST_TWIST: begin
                                    unique case (step)
                                        TW_CUR: begin
                                            x_cur <= m_wb_data_i;
                                            step  <= TW_NXT;
                                        end
                                        TW_NXT: begin
                                            x_nxt <= m_wb_data_i;
                                            step  <= TW_MID;
                                        end
                                        TW_MID: begin
                                            x_mid <= m_wb_data_i;
                                            step  <= TW_WR;
                                        end
                                        default: begin
                                            x_cur <= x_nxt;
                                            step  <= TW_NXT;
                                            if (idx == LAST) begin
                                                state <= ST_OUTPUT;
                                                idx   <= '0;
                                            end else begin
                                                idx <= idx + 1'b1;
                                            end
                                        end
                                    endcase
                                end
                                default: begin
                                    if (idx == LAST) begin
                                        state <= ST_TWIST;
                                        idx   <= '0;
                                        step  <= TW_CUR;
                                    end else begin
                                        idx <= idx + 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end
                default: phase <= BUS_IDLE;
            endcase
        end
    end

    mt_temper u_temper (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (seed_valid_i),
        .valid_i (out_load),
        .data_i  (m_wb_data_i),
        .hold_i  (!rnd_ready_i),
        .valid_o (rnd_valid_o),
        .data_o  (rnd_data_o)
    );

endmodule
